// File: rtl/wb_gpio_deb.sv
// Wishbone GPIO slave: debounced inputs with change-detect interrupt, byte-lane writable outputs.
// Optional NMI output on debounced channel 0 when WB_GPIO_NMI_EN is defined.
module wb_gpio_deb #(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 16,
    parameter int DEB_TICKS = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [1:0]       wb_adr_i,
    input  logic [15:0]      wb_dat_i,
    output logic [15:0]      wb_dat_o,
    input  logic [1:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    input  logic [N_IN-1:0]  gpio_i,
    output logic [N_OUT-1:0] gpio_o,
    input  logic             tick,
    output logic             irq_o
`ifdef WB_GPIO_NMI_EN
    ,
    output logic             nmi_o
`endif
);

    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [N_IN-1:0]  sync1_r;
    logic [N_IN-1:0]  sync2_r;
    logic [N_IN-1:0]  stable_r;
    logic [CW-1:0]    cnt_r [N_IN];
    logic             tick_d_r;
    logic             tick_p_r;
    logic [N_IN-1:0]  accept_s;

    logic [N_OUT-1:0] out_r;
    logic [N_IN-1:0]  en_r;
    logic [N_IN-1:0]  pend_r;
    logic             ack_r;
    logic [15:0]      dat_r;
    logic             irq_r;

    logic             access_s;
    logic             out_we_s;
    logic             en_we_s;
    logic             pend_we_s;
    logic [15:0]      lane_mask_s;
    logic [15:0]      wr_bits_s;
    logic [15:0]      out_merge_s;
    logic [15:0]      en_merge_s;
    logic [15:0]      rd_data_s;
    logic [N_IN-1:0]  pend_clr_s;
    logic [N_IN-1:0]  pend_next_s;

    // A channel is accepted on the tick that completes DEB_TICKS consecutive differing ticks
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (tick_p_r && (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

    // Synchronisers, tick edge detect and per-channel debounce counters
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            stable_r <= '0;
            tick_d_r <= 1'b0;
            tick_p_r <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r  <= gpio_i;
            sync2_r  <= sync1_r;
            tick_d_r <= tick;
            tick_p_r <= tick & ~tick_d_r;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (tick_p_r) begin
                    if (accept_s[i]) begin
                        stable_r[i] <= sync2_r[i];
                        cnt_r[i]    <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Bus decode, byte-lane merge and read mux
    always_comb begin
        access_s    = wb_cyc_i & wb_stb_i & ~ack_r;
        out_we_s    = access_s & wb_we_i & (wb_adr_i == 2'd1);
        en_we_s     = access_s & wb_we_i & (wb_adr_i == 2'd2);
        pend_we_s   = access_s & wb_we_i & (wb_adr_i == 2'd3);
        lane_mask_s = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wr_bits_s   = wb_dat_i & lane_mask_s;
        out_merge_s = (16'(out_r) & ~lane_mask_s) | wr_bits_s;
        en_merge_s  = (16'(en_r) & ~lane_mask_s) | wr_bits_s;
        case (wb_adr_i)
            2'd0:    rd_data_s = 16'(stable_r);
            2'd1:    rd_data_s = 16'(out_r);
            2'd2:    rd_data_s = 16'(en_r);
            2'd3:    rd_data_s = 16'(pend_r);
            default: rd_data_s = 16'h0000;
        endcase
    end

    // Pending update: a hardware set on the same edge as a W1C keeps the bit set
    always_comb begin
        if (pend_we_s) begin
            pend_clr_s = wr_bits_s[N_IN-1:0];
        end else begin
            pend_clr_s = '0;
        end
        pend_next_s = (pend_r & ~pend_clr_s) | accept_s;
    end

    // Bus-visible registers and the one-cycle acknowledge
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r  <= 1'b0;
            dat_r  <= 16'h0000;
            out_r  <= '0;
            en_r   <= '0;
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
            if (access_s) begin
                ack_r <= 1'b1;
                dat_r <= rd_data_s;
            end else begin
                ack_r <= 1'b0;
            end
            if (out_we_s) begin
                out_r <= out_merge_s[N_OUT-1:0];
            end
            if (en_we_s) begin
                en_r <= en_merge_s[N_IN-1:0];
            end
        end
    end

    // Registered interrupt level
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(pend_r & en_r);
        end
    end

`ifdef WB_GPIO_NMI_EN
    logic nmi_r;

    // Channel 0 is an active-low button: NMI while its debounced level is low
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            nmi_r <= 1'b0;
        end else begin
            nmi_r <= ~stable_r[0];
        end
    end

    assign nmi_o = nmi_r;
`endif

    assign wb_ack_o = ack_r;
    assign wb_dat_o = dat_r;
    assign gpio_o   = out_r;
    assign irq_o    = irq_r;

endmodule
